nn_input_framer: RTL
====================

Name: nn_input_framer

Overview:
- Upstream feeder for neural_network.
- Accepts a byte stream of signed 8-bit features through a valid/ready handshake.
- Packs each group of 3 bytes into one 24-bit input vector and buffers completed vectors in a small FIFO.
- Issues each vector to neural_network with a one-cycle start pulse, and only when the network reports ready.

Parameters:
- FIFO_DEPTH, 4, number of completed 24-bit vectors buffered (power of 2, >=2)
- TIMEOUT_CYCLES, 16, idle gap that abandons a partial frame (used only with the optional feature)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous reset, active-low
- s_valid  in  1  upstream byte valid
- s_data  in  8  signed feature byte
- s_last  in  1  marks the final (3rd) byte of a frame
- s_ready  out  1  framer can accept a byte
- nn_ready  in  1  neural_network ready
- nn_start  out  1  one-cycle start pulse to neural_network
- nn_input_data  out  24  packed vector {byte0, byte1, byte2}
- frame_err  out  1  one-cycle pulse on a malformed frame
- fifo_count  out  $clog2(FIFO_DEPTH)+1  vectors currently buffered

Behaviour:
- Reset (rst=0, async): all of the following are 0.
  - s_ready, nn_start, nn_input_data, frame_err, fifo_count
  - assembler byte index and FIFO pointers
  - issue FSM returns to IDLE
- Reset released: s_ready=1 on the first clk edge after release.
- Byte transfer: occurs on any edge where s_valid && s_ready.
  - Byte 0 goes to [23:16], byte 1 to [15:8], byte 2 to [7:0].
  - Bytes are stored raw; no arithmetic or sign extension.
- Frame checking:
  - s_last on byte 2 completes the frame. The vector is written into the FIFO on that edge.
  - s_last on byte 0 or 1 is an error. frame_err pulses the next cycle, the partial frame is discarded and the index returns to 0.
  - No s_last on byte 2 is an error. frame_err pulses, the frame is discarded and the index returns to 0.
- s_ready: registered. Equals (fifo_count < FIFO_DEPTH), computed from next-state count.
  - Full FIFO: s_ready=0 and no bytes are accepted, including bytes 0/1.
- Push and pop on the same edge: fifo_count is unchanged. Allowed while full.
- Issue FSM states: IDLE, ISSUE, GUARD, WAIT.
  - IDLE -> ISSUE when FIFO is non-empty and nn_ready=1. The FIFO is popped on this edge.
  - ISSUE: nn_start=1 for exactly one cycle. nn_input_data holds the popped vector and stays stable until the next ISSUE. Goes to GUARD.
  - GUARD: one cycle. nn_ready is ignored, covering the network's ready deassert latency. Goes to WAIT.
  - WAIT -> IDLE when nn_ready=1.
- Latency: third byte accepted at edge N with FIFO previously empty, FSM in IDLE and nn_ready=1.
  - Vector becomes visible in the FIFO at N+1.
  - nn_start=1 during cycle N+2.
- Ordering: strict FIFO order. Vectors are never dropped once complete.
- Mid-operation reset: all state is cleared. The buffered vectors and any in-flight start are lost; no start is emitted after reset is released until a new frame completes.

Optional Feature:
- Macro NN_FRAMER_TIMEOUT_EN, defined.
  - An idle counter runs while the byte index is non-zero; it resets on each accepted byte.
  - When it reaches TIMEOUT_CYCLES, the partial frame is discarded, the index returns to 0 and frame_err pulses once.
- Macro NN_FRAMER_TIMEOUT_EN, undefined.
  - No counter; a partial frame waits indefinitely.
  - TIMEOUT_CYCLES is unused.

Decomposition:
- Shared package nn_pkg holds:
  - constants NN_FEAT_W=8, NN_NUM_FEAT=3, NN_IN_W=24
  - the issue-FSM state enum
- One sub-module, nn_vec_fifo: a synchronous FIFO of width NN_IN_W and depth FIFO_DEPTH, with push, pop, count, full and empty.
- Assembler and issue FSM stay in the top level.

Test Plan:
- Bytes 01, 02, 03, last on 03, nn_ready=1 -> exactly one nn_start pulse two cycles after byte 03 accepted; nn_input_data=24'h010203.
- Bytes FF, FE, FD, last on FD -> nn_input_data=24'hFFFEFD; frame_err stays 0.
- Bytes 05, 06 with last on 06, then good frame 03, 02, 01 -> one frame_err pulse; single nn_start with 24'h030201.
- Backpressure:
  - Hold nn_ready=0 and send 5 good frames -> s_ready=0 after the 4th frame; fifo_count=4.
  - Then raise nn_ready, toggling it low for 2 cycles after each start -> 4 starts in order; the 5th frame is then accepted and issued.
- Reset asserted between byte 1 and byte 2, then frame 00, 00, 00 sent after release -> no start from the old data; one start with 24'h000000.
- With NN_FRAMER_TIMEOUT_EN, TIMEOUT_CYCLES=16:
  - Send byte 07, then idle 16 cycles -> frame_err pulse.
  - Following frame 01, 02, 03 -> issued as 24'h010203.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared constants and issue-FSM state type for the neural_network input framer.
package nn_pkg;
  localparam int NN_FEAT_W   = 8;
  localparam int NN_NUM_FEAT = 3;
  localparam int NN_IN_W     = NN_FEAT_W * NN_NUM_FEAT;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GUARD,
    ST_WAIT
  } issue_state_t;
endpackage

// File: rtl/nn_vec_fifo.sv
// Synchronous vector FIFO with show-ahead head data, occupancy count and full/empty flags.
import nn_pkg::*;

module nn_vec_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [NN_IN_W-1:0]         push_data,
  input  logic                       pop,
  output logic [NN_IN_W-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [NN_IN_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A push into a full FIFO is only legal when the same edge frees a slot.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/nn_input_framer.sv
// Packs 3-byte frames into 24-bit vectors, buffers them and issues them to neural_network.
// Optional partial-frame timeout is enabled by defining NN_FRAMER_TIMEOUT_EN.
import nn_pkg::*;

module nn_input_framer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  input  logic [NN_FEAT_W-1:0]          s_data,
  input  logic                          s_last,
  output logic                          s_ready,
  input  logic                          nn_ready,
  output logic                          nn_start,
  output logic [NN_IN_W-1:0]            nn_input_data,
  output logic                          frame_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  issue_state_t                  state;
  logic [1:0]                    byte_idx;
  logic [2*NN_FEAT_W-1:0]        partial;
  logic                          accept;
  logic                          last_byte;
  logic                          push;
  logic                          pop;
  logic [NN_IN_W-1:0]            head_data;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [CW-1:0]                 count_next;

  assign accept     = s_valid && s_ready;
  assign last_byte  = (byte_idx == 2'(NN_NUM_FEAT - 1));
  assign push       = accept && last_byte && s_last && (!fifo_full || pop);
  assign pop        = (state == ST_IDLE) && !fifo_empty && nn_ready;
  assign count_next = fifo_count + CW'(push) - CW'(pop);

  nn_vec_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({partial, s_data}),
    .pop       (pop),
    .pop_data  (head_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef NN_FRAMER_TIMEOUT_EN
  logic [$clog2(TIMEOUT_CYCLES+1)-1:0] idle_cnt;
`endif

  // Byte assembler: bytes shift in MSB-first so the last byte lands in [7:0].
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_idx  <= '0;
      partial   <= '0;
      frame_err <= 1'b0;
      s_ready   <= 1'b0;
`ifdef NN_FRAMER_TIMEOUT_EN
      idle_cnt  <= '0;
`endif
    end else begin
      frame_err <= 1'b0;
      s_ready   <= (count_next < CW'(FIFO_DEPTH));
      if (accept) begin
`ifdef NN_FRAMER_TIMEOUT_EN
        idle_cnt <= '0;
`endif
        if (last_byte) begin
          byte_idx  <= '0;
          frame_err <= !s_last;
        end else if (s_last) begin
          byte_idx  <= '0;
          frame_err <= 1'b1;
        end else begin
          partial  <= {partial[NN_FEAT_W-1:0], s_data};
          byte_idx <= byte_idx + 1'b1;
        end
      end
`ifdef NN_FRAMER_TIMEOUT_EN
      else if (byte_idx != '0) begin
        if (idle_cnt == $bits(idle_cnt)'(TIMEOUT_CYCLES - 1)) begin
          idle_cnt  <= '0;
          byte_idx  <= '0;
          frame_err <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
`endif
    end
  end

  // Issue FSM; GUARD masks nn_ready while the network drops it after a start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      nn_start      <= 1'b0;
      nn_input_data <= '0;
    end else begin
      nn_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            nn_input_data <= head_data;
            nn_start      <= 1'b1;
            state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_GUARD;
        ST_GUARD: state <= ST_WAIT;
        ST_WAIT:  if (nn_ready) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end
endmodule
